// File: rtl/rv32im_bus_arbiter.sv
// Wishbone bus arbiter for N masters sharing one slave. There is always exactly one owner:
// the grant is never idle, parks on DEFAULT_MASTER, and supports an optional stall timeout.
module rv32im_bus_arbiter #(
  parameter int XLEN           = 32,
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 1,
  parameter int RR_MODE        = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_MASTERS-1:0]          req_i,
  output logic [NUM_MASTERS-1:0]          grant_o,
  input  logic [NUM_MASTERS*(XLEN-2)-1:0] m_adr_i,
  input  logic [NUM_MASTERS*XLEN-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]        m_sel_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  output logic [XLEN-3:0]                 adr_o,
  output logic [XLEN-1:0]                 dat_o,
  output logic [3:0]                      sel_o,
  output logic                            cyc_o,
  output logic                            stb_o,
  output logic                            we_o,
  input  logic                            ack_i,
  input  logic                            err_i,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic                            timeout_o
);

  localparam int AW = XLEN - 2;
  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_owner;
  logic [IW-1:0]          r_rr_ptr;

  logic [IW-1:0] w_fp_idx;
  logic [IW-1:0] w_rr_idx;
  logic [IW-1:0] w_win_idx;
  logic [IW-1:0] w_next_owner;
  logic          w_rr_upd;
  logic          w_release;
  logic          w_timeout;

  // Fixed-priority and round-robin winner search over the current requests
  always_comb begin
    logic          v_fp_found;
    logic          v_rr_found;
    logic [IW-1:0] v_idx;
    v_fp_found = 1'b0;
    v_rr_found = 1'b0;
    w_fp_idx   = '0;
    w_rr_idx   = '0;
    v_idx      = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      v_idx      = IW'(i);
      w_fp_idx   = (req_i[v_idx] && !v_fp_found) ? v_idx : w_fp_idx;
      v_fp_found = v_fp_found | req_i[v_idx];
    end
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      v_idx      = IW'((int'(r_rr_ptr) + k) % NUM_MASTERS);
      w_rr_idx   = (req_i[v_idx] && !v_rr_found) ? v_idx : w_rr_idx;
      v_rr_found = v_rr_found | req_i[v_idx];
    end
    w_win_idx = (RR_MODE != 0) ? w_rr_idx : w_fp_idx;
  end

  // Next owner: hold while the owner requests or keeps its cycle open, else winner or park
  always_comb begin
    w_release    = ~req_i[r_owner] & ~m_cyc_i[r_owner];
    w_next_owner = r_owner;
    w_rr_upd     = 1'b0;
    if (w_release && (|req_i)) begin
      w_next_owner = w_win_idx;
      w_rr_upd     = 1'b1;
    end else if (w_release) begin
      w_next_owner = DEF_IDX;
      w_rr_upd     = 1'b0;
    end else begin
      w_next_owner = r_owner;
      w_rr_upd     = 1'b0;
    end
  end

  // Grant, owner index and round-robin pointer registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_grant  <= DEF_GRANT;
      r_owner  <= DEF_IDX;
      r_rr_ptr <= DEF_IDX;
    end else begin
      r_grant  <= NUM_MASTERS'(1) << w_next_owner;
      r_owner  <= w_next_owner;
      r_rr_ptr <= w_rr_upd ? w_next_owner : r_rr_ptr;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] r_to_cnt;
      logic          w_stall;
      logic          w_tc;

      assign w_stall = m_cyc_i[r_owner] & m_stb_i[r_owner] & ~ack_i & ~err_i;
      assign w_tc    = w_stall & (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

      // Stall counter; a slave response in the terminal cycle wins because it ends the stall
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          r_to_cnt <= '0;
        end else if ((w_next_owner != r_owner) || !w_stall || w_tc) begin
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + CW'(1);
        end
      end

      assign w_timeout = w_tc & ~reset_i;
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  assign grant_o   = r_grant;
  assign timeout_o = w_timeout;
  assign adr_o     = m_adr_i[r_owner*AW +: AW];
  assign dat_o     = m_dat_i[r_owner*XLEN +: XLEN];
  assign sel_o     = m_sel_i[r_owner*4 +: 4];
  assign cyc_o     = m_cyc_i[r_owner];
  assign stb_o     = m_stb_i[r_owner];
  assign we_o      = m_we_i[r_owner];

  // Route the slave response to the owner only; suppressed while reset aborts the grant
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    if (reset_i) begin
      m_ack_o = '0;
      m_err_o = '0;
    end else begin
      m_ack_o = ack_i ? r_grant : '0;
      m_err_o = (err_i | w_timeout) ? r_grant : '0;
    end
  end

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// Directed bench: a fixed-priority instance with an 8-cycle timeout and a round-robin
// instance without one, both driven from the same master-side stimulus.
module tb_rv32im_bus_arbiter;

  localparam int N    = 4;
  localparam int XLEN = 32;
  localparam int AW   = XLEN - 2;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              reset_i;
  logic [N-1:0]      req_i, m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0]   m_adr_i;
  logic [N*XLEN-1:0] m_dat_i;
  logic [N*4-1:0]    m_sel_i;
  logic              ack_i, err_i;

  logic [N-1:0]    f_grant, f_ack, f_err, r_grant, r_ack, r_err;
  logic [AW-1:0]   f_adr, r_adr;
  logic [XLEN-1:0] f_dat, r_dat;
  logic [3:0]      f_sel, r_sel;
  logic            f_cyc, f_stb, f_we, f_to, r_cyc, r_stb, r_we, r_to;

  int tests_run    = 0;
  int tests_failed = 0;

  rv32im_bus_arbiter #(.XLEN(XLEN), .NUM_MASTERS(N), .DEFAULT_MASTER(1), .RR_MODE(0), .TIMEOUT_CYCLES(8)) u_dut_fix (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .grant_o(f_grant),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .adr_o(f_adr), .dat_o(f_dat), .sel_o(f_sel), .cyc_o(f_cyc), .stb_o(f_stb), .we_o(f_we),
    .ack_i(ack_i), .err_i(err_i), .m_ack_o(f_ack), .m_err_o(f_err), .timeout_o(f_to)
  );

  rv32im_bus_arbiter #(.XLEN(XLEN), .NUM_MASTERS(N), .DEFAULT_MASTER(1), .RR_MODE(1), .TIMEOUT_CYCLES(0)) u_dut_rr (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .grant_o(r_grant),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .adr_o(r_adr), .dat_o(r_dat), .sel_o(r_sel), .cyc_o(r_cyc), .stb_o(r_stb), .we_o(r_we),
    .ack_i(ack_i), .err_i(err_i), .m_ack_o(r_ack), .m_err_o(r_err), .timeout_o(r_to)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [N-1:0] rr_prev;
  logic [N-1:0] rr_exp;
  int           rr_seq [5] = '{0, 2, 3, 0, 2};

  initial begin
    reset_i = 1'b1;
    req_i   = '0;
    m_cyc_i = '0;
    m_stb_i = '0;
    ack_i   = 1'b0;
    err_i   = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_adr_i[k*AW +: AW]     = AW'(32'h100 + k);
      m_dat_i[k*XLEN +: XLEN] = 32'hA0A0_0000 + 32'(k);
      m_sel_i[k*4 +: 4]       = 4'(1 << k);
      m_we_i[k]               = k[0];
    end

    // reset before any clock edge: parked on master 1, outputs mirror master 1
    #2;
    check("rst_grant_noclk", f_grant, 4'b0010);
    check("rst_grant_rr", r_grant, 4'b0010);
    check("rst_adr", f_adr, 30'h101);
    check("rst_timeout", f_to, 1'b0);
    tick();
    tick();
    check("rst_grant_clk", f_grant, 4'b0010);
    reset_i = 1'b0;
    tick();
    check("post_rst_grant", f_grant, 4'b0010);
    check("post_rst_dat", f_dat, 32'hA0A0_0001);
    check("post_rst_sel", f_sel, 4'b0010);
    check("post_rst_we", f_we, 1'b1);

    // fixed priority from park, then direct hand-over without parking
    req_i = 4'b1101;
    tick();
    check("fp_lowest", f_grant, 4'b0001);
    check("fp_adr0", f_adr, 30'h100);
    req_i = 4'b1100;
    tick();
    check("fp_handover", f_grant, 4'b0100);
    check("fp_dat2", f_dat, 32'hA0A0_0002);
    ack_i = 1'b1;
    #1;
    check("route_ack", f_ack, 4'b0100);
    ack_i = 1'b0;
    err_i = 1'b1;
    #1;
    check("route_err", f_err, 4'b0100);
    err_i = 1'b0;

    // no preemption by a lower index
    req_i = 4'b1101;
    tick();
    check("no_preempt", f_grant, 4'b0100);

    // owner 2 drops req but holds cyc for three cycles
    req_i   = 4'b1000;
    m_cyc_i = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("cyc_hold", f_grant, 4'b0100);
      check("cyc_hold_out", f_cyc, 1'b1);
    end
    m_cyc_i = 4'b0000;
    tick();
    check("cyc_release", f_grant, 4'b1000);

    // asynchronous reset mid-cycle while master 3 owns
    #2;
    reset_i = 1'b1;
    #1;
    check("async_rst_grant", f_grant, 4'b0010);
    ack_i = 1'b1;
    #1;
    check("async_rst_no_ack", f_ack, 4'b0000);
    ack_i = 1'b0;
    tick();
    reset_i = 1'b0;
    req_i   = 4'b0000;
    tick();

    // parked default yields, then grant returns to park
    req_i = 4'b0100;
    tick();
    check("park_yield", f_grant, 4'b0100);
    req_i = 4'b0000;
    tick();
    check("park_return", f_grant, 4'b0010);

    // timeout: owner 0 stalls, pulse in the 8th stalled cycle
    req_i = 4'b0001;
    tick();
    check("to_owner", f_grant, 4'b0001);
    m_cyc_i = 4'b0001;
    m_stb_i = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check("to_pulse", f_to, (k == 8) ? 1'b1 : 1'b0);
      check("to_err", f_err, (k == 8) ? 4'b0001 : 4'b0000);
      if (k == 8) check("to_rr_off", r_to, 1'b0);
      tick();
    end
    #1;
    check("to_after", f_to, 1'b0);
    m_stb_i = 4'b0000;
    tick();
    m_stb_i = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      #1;
      check("to_restall", f_to, 1'b0);
      tick();
    end
    ack_i = 1'b1;
    #1;
    check("to_ack_wins", f_to, 1'b0);
    check("to_ack_routed", f_ack, 4'b0001);
    check("to_ack_no_err", f_err, 4'b0000);
    tick();
    ack_i = 1'b0;
    #1;
    check("to_ack_cleared", f_to, 1'b0);
    req_i   = 4'b0000;
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    tick();

    // round-robin: prime pointer on master 3, then masters 0,2,3 take turns
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
    req_i = 4'b1000;
    tick();
    check("rr_prime", r_grant, 4'b1000);
    rr_prev = 4'b1000;
    for (int s = 0; s < 5; s++) begin
      req_i = 4'b1101 & ~rr_prev;
      tick();
      rr_exp = 4'(1 << rr_seq[s]);
      check("rr_seq", r_grant, rr_exp);
      rr_prev = rr_exp;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
